// File: rtl/can_pkg.sv
// Shared CAN controller types: scheduler state encoding, error-state constant
// and the bus-arbitration key used to rank transmit mailboxes.
package can_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SELECT,
    LAUNCH,
    WAIT
  } sched_state_t;

  localparam logic [1:0] ERR_BUSOFF = 2'd2;

  // Key mirrors the on-wire arbitration field order; numerically lower wins the bus
  function automatic logic [31:0] arb_key(input logic [28:0] id, input logic ext, input logic rtr);
    if (ext) return {id[28:18], 1'b1, 1'b1, id[17:0], rtr};
    else     return {id[28:18], rtr, 1'b0, 18'b0, 1'b0};
  endfunction

endpackage

// File: rtl/tx_prio_select.sv
// Combinational minimum-key search across candidate mailboxes; ties go to the
// lowest index because only a strictly smaller key replaces the current best.
module tx_prio_select #(
  parameter int unsigned NUM_MB = 4
) (
  input  logic [NUM_MB-1:0]         cand,
  input  logic [32*NUM_MB-1:0]      keys,
  output logic                      valid,
  output logic [$clog2(NUM_MB)-1:0] index
);
  localparam int unsigned IW = $clog2(NUM_MB);

  logic [31:0] best;

  always_comb begin
    valid = 1'b0;
    index = '0;
    best  = '1;
    for (int unsigned i = 0; i < NUM_MB; i++) begin
      if (cand[i] && (!valid || (keys[32*i +: 32] < best))) begin
        valid = 1'b1;
        index = IW'(i);
        best  = keys[32*i +: 32];
      end
    end
  end

endmodule

// File: rtl/tx_mailbox_sched.sv
// CAN transmit scheduler: launches the pending mailbox that would win bus
// arbitration and retires, requeues or fails it on the transmitter's result.
module tx_mailbox_sched
  import can_pkg::*;
#(
  parameter int unsigned NUM_MB    = 4,
  parameter int unsigned MAX_RETRY = 3
) (
  input  logic                      clk,
  input  logic                      nRST,
  input  logic [NUM_MB-1:0]         req,
  input  logic [NUM_MB-1:0]         abort,
  input  logic [29*NUM_MB-1:0]      mb_id,
  input  logic [NUM_MB-1:0]         mb_ext,
  input  logic [NUM_MB-1:0]         mb_rtr,
  input  logic [4*NUM_MB-1:0]       mb_dlc,
  input  logic                      bus_idle,
  input  logic [1:0]                error_state,
  input  logic                      tx_done,
  input  logic                      tx_arb_lost,
  input  logic                      tx_error,
  output logic                      tx_start,
  output logic [28:0]               tx_id,
  output logic                      tx_ext,
  output logic                      tx_rtr,
  output logic [3:0]                tx_dlc,
  output logic [$clog2(NUM_MB)-1:0] tx_sel,
  output logic [NUM_MB-1:0]         pending,
  output logic                      sched_busy,
  output logic [NUM_MB-1:0]         done_pulse,
  output logic [NUM_MB-1:0]         fail_pulse
);
  localparam int unsigned IW = $clog2(NUM_MB);

  sched_state_t             state, state_nxt;
  logic [NUM_MB-1:0]        pending_nxt, done_nxt, fail_nxt;
  logic [NUM_MB-1:0]        cand, flight;
  logic [32*NUM_MB-1:0]     keys;
  logic                     sel_valid;
  logic [IW-1:0]            sel_idx;
  logic                     abort_rec, abort_rec_nxt, abort_eff;
  logic                     load_hdr, bus_off;
  logic [3:0]               retry_cnt, retry_nxt;

  always_comb begin
    keys = '0;
    for (int unsigned i = 0; i < NUM_MB; i++)
      keys[32*i +: 32] = arb_key(mb_id[29*i +: 29], mb_ext[i], mb_rtr[i]);
  end

  // A mailbox aborted in the SELECT cycle must not be chosen
  assign cand = pending & ~abort;

  tx_prio_select #(.NUM_MB(NUM_MB)) u_prio (
    .cand  (cand),
    .keys  (keys),
    .valid (sel_valid),
    .index (sel_idx)
  );

  assign bus_off    = (error_state == ERR_BUSOFF);
  assign tx_start   = (state == LAUNCH);
  assign sched_busy = (state == LAUNCH) || (state == WAIT);

  always_comb begin
    flight = '0;
    if (sched_busy) flight[tx_sel] = 1'b1;
  end

  assign abort_eff = abort_rec | (|(abort & flight));

  always_comb begin
    state_nxt     = state;
    pending_nxt   = pending;
    done_nxt      = '0;
    fail_nxt      = '0;
    abort_rec_nxt = abort_rec;
    retry_nxt     = retry_cnt;
    load_hdr      = 1'b0;

    for (int unsigned i = 0; i < NUM_MB; i++) begin
      if (abort[i]) begin
        if (pending[i] && !flight[i]) begin
          pending_nxt[i] = 1'b0;
          fail_nxt[i]    = 1'b1;
        end
      end else if (req[i]) begin
        pending_nxt[i] = 1'b1;
      end
    end

    case (state)
      IDLE: begin
        abort_rec_nxt = 1'b0;
        if ((|pending) && bus_idle && !bus_off) state_nxt = SELECT;
      end
      SELECT: begin
        if (sel_valid && !bus_off) begin
          load_hdr  = 1'b1;
          state_nxt = LAUNCH;
          if (sel_idx != tx_sel) retry_nxt = '0;
        end else begin
          state_nxt = IDLE;
        end
      end
      LAUNCH: begin
        abort_rec_nxt = abort_eff;
        state_nxt     = WAIT;
      end
      WAIT: begin
        abort_rec_nxt = abort_eff;
        if (tx_done) begin
          pending_nxt[tx_sel] = 1'b0;
          done_nxt[tx_sel]    = 1'b1;
          retry_nxt           = '0;
          state_nxt           = IDLE;
        end else if (tx_error) begin
          if ((retry_cnt == 4'(MAX_RETRY)) || abort_eff) begin
            pending_nxt[tx_sel] = 1'b0;
            fail_nxt[tx_sel]    = 1'b1;
            retry_nxt           = '0;
          end else begin
            retry_nxt = retry_cnt + 4'd1;
          end
          state_nxt = IDLE;
        end else if (tx_arb_lost) begin
          if (abort_eff) begin
            pending_nxt[tx_sel] = 1'b0;
            fail_nxt[tx_sel]    = 1'b1;
          end
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nRST) begin
      state      <= IDLE;
      pending    <= '0;
      done_pulse <= '0;
      fail_pulse <= '0;
      abort_rec  <= 1'b0;
      retry_cnt  <= '0;
      tx_sel     <= '0;
      tx_id      <= '0;
      tx_ext     <= 1'b0;
      tx_rtr     <= 1'b0;
      tx_dlc     <= '0;
    end else begin
      state      <= state_nxt;
      pending    <= pending_nxt;
      done_pulse <= done_nxt;
      fail_pulse <= fail_nxt;
      abort_rec  <= abort_rec_nxt;
      retry_cnt  <= retry_nxt;
      if (load_hdr) begin
        tx_sel <= sel_idx;
        tx_id  <= mb_id[29*sel_idx +: 29];
        tx_ext <= mb_ext[sel_idx];
        tx_rtr <= mb_rtr[sel_idx];
        tx_dlc <= mb_dlc[4*sel_idx +: 4];
      end
    end
  end

endmodule
